div_result_serializer: RTL

//  Drains 65-bit divider results from the output FIFO and serializes each into BEAT_WIDTH-bit beats on a valid/ready link.

---
 rtl/div_result_serializer_pkg.sv | 16 +
 rtl/div_result_serializer_if.sv | 48 ++++
 rtl/div_result_serializer.sv | 101 ++++++++++
 3 files changed

// File: rtl/div_result_serializer_pkg.sv
// Shared constants and FSM encoding for the divider result serializer.
// Optional even-parity output is enabled by defining DIV_RES_SER_PARITY_EN.
package div_result_serializer_pkg;

    localparam int unsigned DATA_WIDTH  = 65;
    localparam int unsigned BEAT_WIDTH  = 16;
    localparam int unsigned NUM_BEATS   = (DATA_WIDTH + BEAT_WIDTH - 1) / BEAT_WIDTH;
    localparam int unsigned CNT_WIDTH   = $clog2(NUM_BEATS);
    localparam int unsigned SHREG_WIDTH = NUM_BEATS * BEAT_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/div_result_serializer_if.sv
// FIFO-side and beat-side handshake bundle of the divider result serializer.
// beat_par_o exists only when DIV_RES_SER_PARITY_EN is defined.
interface div_result_serializer_if;
    import div_result_serializer_pkg::*;

    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_nempty_i;
    logic                  fifo_ready_o;
    logic [BEAT_WIDTH-1:0] beat_data_o;
    logic                  beat_valid_o;
    logic                  beat_ready_i;
    logic                  beat_last_o;
    logic                  busy_o;
`ifdef DIV_RES_SER_PARITY_EN
    logic                  beat_par_o;
`endif

    // Serializer side
    modport slave (
        input  fifo_data_i,
        input  fifo_nempty_i,
        input  beat_ready_i,
        output fifo_ready_o,
        output beat_data_o,
        output beat_valid_o,
        output beat_last_o,
        output busy_o
`ifdef DIV_RES_SER_PARITY_EN
        , output beat_par_o
`endif
    );

    // FIFO / sink side
    modport master (
        output fifo_data_i,
        output fifo_nempty_i,
        output beat_ready_i,
        input  fifo_ready_o,
        input  beat_data_o,
        input  beat_valid_o,
        input  beat_last_o,
        input  busy_o
`ifdef DIV_RES_SER_PARITY_EN
        , input beat_par_o
`endif
    );

endinterface

// File: rtl/div_result_serializer.sv
// Pops 65-bit divider results from the FIFO head and emits them LSB-first as 16-bit beats.
// DIV_RES_SER_PARITY_EN adds a registered even-parity bit alongside each beat.
module div_result_serializer
    import div_result_serializer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    div_result_serializer_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_BEATS - 1);

    ser_state_t             r_state;
    logic [SHREG_WIDTH-1:0] r_shreg;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_last;
`ifdef DIV_RES_SER_PARITY_EN
    logic                   r_par;
`endif

    logic                   w_accept;
    logic                   w_pop;
    logic [SHREG_WIDTH-1:0] w_load;
    logic [SHREG_WIDTH-1:0] w_shift;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;

    always_comb begin
        w_accept  = (r_state == SEND) && bus.beat_ready_i;
        // Pop in IDLE, or on the accepted last beat for back-to-back entries
        w_pop     = !rst_i && bus.fifo_nempty_i &&
                    ((r_state == IDLE) || (w_accept && r_last));
        w_load    = SHREG_WIDTH'(bus.fifo_data_i);
        w_shift   = r_shreg >> BEAT_WIDTH;
        w_cnt_inc = r_cnt + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
`ifdef DIV_RES_SER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= SEND;
                        r_shreg <= w_load;
                        r_cnt   <= '0;
                        r_last  <= (LAST_CNT == '0);
`ifdef DIV_RES_SER_PARITY_EN
                        r_par   <= ^w_load[BEAT_WIDTH-1:0];
`endif
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (!r_last) begin
                            r_shreg <= w_shift;
                            r_cnt   <= w_cnt_inc;
                            r_last  <= (w_cnt_inc == LAST_CNT);
`ifdef DIV_RES_SER_PARITY_EN
                            r_par   <= ^w_shift[BEAT_WIDTH-1:0];
`endif
                        end else if (w_pop) begin
                            r_shreg <= w_load;
                            r_cnt   <= '0;
                            r_last  <= (LAST_CNT == '0);
`ifdef DIV_RES_SER_PARITY_EN
                            r_par   <= ^w_load[BEAT_WIDTH-1:0];
`endif
                        end else begin
                            // Clear the datapath so idle outputs read as zero
                            r_state <= IDLE;
                            r_shreg <= '0;
                            r_cnt   <= '0;
                            r_last  <= 1'b0;
`ifdef DIV_RES_SER_PARITY_EN
                            r_par   <= 1'b0;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_ready_o = w_pop;
    assign bus.beat_valid_o = (r_state == SEND);
    assign bus.beat_data_o  = r_shreg[BEAT_WIDTH-1:0];
    assign bus.beat_last_o  = r_last;
    assign bus.busy_o       = (r_state == SEND);
`ifdef DIV_RES_SER_PARITY_EN
    assign bus.beat_par_o   = r_par;
`endif

endmodule
